// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and load/store.
// Sequences one access at a time through IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_arbiter #(
  parameter int         LATENCY    = 0,
  parameter logic [2:0] IFU_READOP = 3'h2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  input  logic [2:0]  lsu_readop,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,
  output logic        mem_access,
  output logic        mem_read,
  output logic        mem_wen,
  output logic [2:0]  mem_readop,
  output logic [7:0]  mem_wmask,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  logic [1:0]  state;
  logic        last_grant;
  logic        owner;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  wmask_q;
  logic [2:0]  readop_q;
  logic        wen_q;
  logic [31:0] resp_data;
  logic        resp_fresh;
  logic        grant_ifu;
  logic        grant_lsu;
  logic        in_resp;
  logic        resp_take;
  logic [31:0] rdata_cur;

  function automatic logic [31:0] load_result(input logic wen, input logic [31:0] rdata);
    return wen ? 32'h0 : rdata;
  endfunction

  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    if (state == S_IDLE) begin
      if (ifu_req_valid && lsu_req_valid) begin
        if (last_grant == OWN_LSU) grant_ifu = 1'b1;
        else                       grant_lsu = 1'b1;
      end else if (ifu_req_valid) begin
        grant_ifu = 1'b1;
      end else if (lsu_req_valid) begin
        grant_lsu = 1'b1;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  // With zero latency RESP is entered straight from ISSUE, so the first RESP
  // cycle forwards the now-settled memory data and registers it for the stall.
  always_comb begin
    rdata_cur = resp_fresh ? load_result(wen_q, mem_rdata) : resp_data;
  end

  assign in_resp        = (state == S_RESP);
  assign ifu_resp_valid = in_resp && (owner == OWN_IFU);
  assign lsu_resp_valid = in_resp && (owner == OWN_LSU);
  assign ifu_rdata      = ifu_resp_valid ? rdata_cur : 32'h0;
  assign lsu_rdata      = lsu_resp_valid ? rdata_cur : 32'h0;
  assign resp_take      = (owner == OWN_IFU) ? (ifu_resp_valid && ifu_resp_ready)
                                             : (lsu_resp_valid && lsu_resp_ready);

  assign mem_access = (state == S_ISSUE);
  assign mem_read   = mem_access && !wen_q;
  assign mem_wen    = mem_access && wen_q;
  assign mem_readop = readop_q;
  assign mem_wmask  = wmask_q;
  assign mem_raddr  = addr_q;
  assign mem_waddr  = addr_q;
  assign mem_wdata  = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= OWN_LSU;
      owner      <= OWN_IFU;
      wait_cnt   <= 4'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wmask_q    <= 8'h0;
      readop_q   <= 3'h0;
      wen_q      <= 1'b0;
      resp_data  <= 32'h0;
      resp_fresh <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_ifu) begin
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            addr_q     <= ifu_addr;
            wen_q      <= 1'b0;
            wdata_q    <= 32'h0;
            wmask_q    <= 8'h0;
            readop_q   <= IFU_READOP;
            state      <= S_ISSUE;
          end else if (grant_lsu) begin
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            addr_q     <= lsu_addr;
            wen_q      <= lsu_wen;
            wdata_q    <= lsu_wdata;
            wmask_q    <= lsu_wmask;
            readop_q   <= lsu_readop;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (LATENCY > 0) begin
            wait_cnt <= 4'(LATENCY - 1);
            state    <= S_WAIT;
          end else begin
            resp_fresh <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            resp_data <= load_result(wen_q, mem_rdata);
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_fresh) begin
            resp_data  <= rdata_cur;
            resp_fresh <= 1'b0;
          end
          if (resp_take) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (LATENCY 0 and 3), directed vectors,
// multi-cycle corner sequences and a randomized run against a transaction model.
module tb_mem_arbiter;

  logic clk;
  logic rst;

  logic [1:0]  ifu_req_valid;
  wire  [1:0]  ifu_req_ready;
  logic [31:0] ifu_addr [2];
  wire  [1:0]  ifu_resp_valid;
  logic [1:0]  ifu_resp_ready;
  wire  [31:0] ifu_rdata [2];
  logic [1:0]  lsu_req_valid;
  wire  [1:0]  lsu_req_ready;
  logic [1:0]  lsu_wen;
  logic [31:0] lsu_addr [2];
  logic [31:0] lsu_wdata [2];
  logic [7:0]  lsu_wmask [2];
  logic [2:0]  lsu_readop [2];
  wire  [1:0]  lsu_resp_valid;
  logic [1:0]  lsu_resp_ready;
  wire  [31:0] lsu_rdata [2];
  wire  [1:0]  mem_access;
  wire  [1:0]  mem_read;
  wire  [1:0]  mem_wen;
  wire  [2:0]  mem_readop [2];
  wire  [7:0]  mem_wmask [2];
  wire  [31:0] mem_raddr [2];
  wire  [31:0] mem_waddr [2];
  wire  [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  int errors = 0;
  int checks = 0;
  int wr_cnt [2];
  bit force_en = 0;
  logic [31:0] force_val = 32'h0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(.LATENCY(g * 3), .IFU_READOP(3'h2)) u_dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid[g]), .ifu_req_ready(ifu_req_ready[g]),
      .ifu_addr(ifu_addr[g]), .ifu_resp_valid(ifu_resp_valid[g]),
      .ifu_resp_ready(ifu_resp_ready[g]), .ifu_rdata(ifu_rdata[g]),
      .lsu_req_valid(lsu_req_valid[g]), .lsu_req_ready(lsu_req_ready[g]),
      .lsu_wen(lsu_wen[g]), .lsu_addr(lsu_addr[g]), .lsu_wdata(lsu_wdata[g]),
      .lsu_wmask(lsu_wmask[g]), .lsu_readop(lsu_readop[g]),
      .lsu_resp_valid(lsu_resp_valid[g]), .lsu_resp_ready(lsu_resp_ready[g]),
      .lsu_rdata(lsu_rdata[g]),
      .mem_access(mem_access[g]), .mem_read(mem_read[g]), .mem_wen(mem_wen[g]),
      .mem_readop(mem_readop[g]), .mem_wmask(mem_wmask[g]),
      .mem_raddr(mem_raddr[g]), .mem_waddr(mem_waddr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory data depends on address and load type, so a wrong readop shows up.
  function automatic logic [31:0] mem_fn(input logic [31:0] a, input logic [2:0] op);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF ^ {29'h0, op};
  endfunction

  // Memory: data appears the cycle after the issue cycle and holds until the next read.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_access[i] && mem_read[i])
        mem_rdata[i] <= force_en ? force_val : mem_fn(mem_raddr[i], mem_readop[i]);
      if (mem_access[i] && mem_wen[i])
        wr_cnt[i] <= wr_cnt[i] + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk({tag, " ctl"}, {25'h0, ifu_req_ready[i], lsu_req_ready[i], ifu_resp_valid[i],
        lsu_resp_valid[i], mem_access[i], mem_read[i], mem_wen[i]}, 32'h0);
    chk({tag, " rdata"}, ifu_rdata[i] | lsu_rdata[i], 32'h0);
    chk({tag, " maddr"}, mem_raddr[i] | mem_waddr[i], 32'h0);
    chk({tag, " mfields"}, mem_wdata[i] | {21'h0, mem_wmask[i], mem_readop[i]}, 32'h0);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      ifu_req_valid[i] = 0; lsu_req_valid[i] = 0; lsu_wen[i] = 0;
      ifu_resp_ready[i] = 0; lsu_resp_ready[i] = 0;
      ifu_addr[i] = 0; lsu_addr[i] = 0; lsu_wdata[i] = 0;
      lsu_wmask[i] = 0; lsu_readop[i] = 0;
    end
  endtask

  task automatic do_reset(input int i);
    clear_inputs();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_zero(i, "reset");
    next_cyc();
    rst = 0;
  endtask

  typedef struct {
    int          inst;
    bit          lsu;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
    logic [2:0]  readop;
    bit          frc;
    logic [31:0] memval;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic run_txn(input vec_t v);
    int i = v.inst;
    int lat = v.inst * 3;
    int w0 = wr_cnt[i];
    logic [2:0] exp_op = v.lsu ? v.readop : 3'h2;
    force_en = v.frc;
    force_val = v.memval;
    ifu_resp_ready[i] = 1;
    lsu_resp_ready[i] = 1;
    if (v.lsu) begin
      lsu_req_valid[i] = 1; lsu_wen[i] = v.wen; lsu_addr[i] = v.addr;
      lsu_wdata[i] = v.wdata; lsu_wmask[i] = v.wmask; lsu_readop[i] = v.readop;
    end else begin
      ifu_req_valid[i] = 1; ifu_addr[i] = v.addr;
    end
    @(negedge clk);
    chk("hs ready", v.lsu ? lsu_req_ready[i] : ifu_req_ready[i], 1);
    chk("hs other ready", v.lsu ? ifu_req_ready[i] : lsu_req_ready[i], 0);
    chk("hs no access", mem_access[i], 0);
    next_cyc();
    ifu_req_valid[i] = 0;
    lsu_req_valid[i] = 0;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      chk($sformatf("access c%0d", c), mem_access[i], (c == 1));
      if (c == 1) begin
        chk("mem_read", mem_read[i], !v.wen);
        chk("mem_wen", mem_wen[i], v.wen);
        chk("mem_raddr", mem_raddr[i], v.addr);
        chk("mem_waddr", mem_waddr[i], v.addr);
        chk("mem_readop", mem_readop[i], exp_op);
        if (v.wen) begin
          chk("mem_wdata", mem_wdata[i], v.wdata);
          chk("mem_wmask", mem_wmask[i], v.wmask);
        end
      end
      chk($sformatf("resp_valid c%0d", c), v.lsu ? lsu_resp_valid[i] : ifu_resp_valid[i],
          (c == lat + 2));
      chk($sformatf("other resp c%0d", c), v.lsu ? ifu_resp_valid[i] : lsu_resp_valid[i], 0);
      if (c == lat + 2) chk("rdata", v.lsu ? lsu_rdata[i] : ifu_rdata[i], v.exp_rdata);
      next_cyc();
    end
    @(negedge clk);
    chk("resp done", {30'h0, ifu_resp_valid[i], lsu_resp_valid[i]}, 0);
    chk("write count", wr_cnt[i] - w0, v.wen ? 1 : 0);
    next_cyc();
    force_en = 0;
  endtask

  task automatic seq_alternate();
    int i = 0;
    logic [31:0] ia = 32'h8000_0200;
    logic [31:0] la = 32'h8000_0300;
    do_reset(i);
    ifu_req_valid[i] = 1; ifu_addr[i] = ia;
    lsu_req_valid[i] = 1; lsu_addr[i] = la; lsu_readop[i] = 3'h2; lsu_wen[i] = 0;
    ifu_resp_ready[i] = 1; lsu_resp_ready[i] = 1;
    for (int g = 0; g < 3; g++) begin
      bit exp_lsu = (g == 1);
      @(negedge clk);
      chk($sformatf("alt%0d ifu_rdy", g), ifu_req_ready[i], !exp_lsu);
      chk($sformatf("alt%0d lsu_rdy", g), lsu_req_ready[i], exp_lsu);
      next_cyc();
      @(negedge clk);
      chk($sformatf("alt%0d busy rdy", g), {30'h0, ifu_req_ready[i], lsu_req_ready[i]}, 0);
      next_cyc();
      @(negedge clk);
      chk($sformatf("alt%0d resp", g), {30'h0, ifu_resp_valid[i], lsu_resp_valid[i]},
          exp_lsu ? 32'h1 : 32'h2);
      chk($sformatf("alt%0d rdata", g), exp_lsu ? lsu_rdata[i] : ifu_rdata[i],
          mem_fn(exp_lsu ? la : ia, 3'h2));
      next_cyc();
    end
    clear_inputs();
    repeat (4) next_cyc();
  endtask

  task automatic seq_backpressure();
    int i = 1;
    logic [31:0] la = 32'h8000_4002;
    logic [31:0] ia = 32'h8000_0100;
    logic [31:0] exp_d = mem_fn(la, 3'h1);
    int w0;
    do_reset(i);
    w0 = wr_cnt[i];
    lsu_req_valid[i] = 1; lsu_wen[i] = 0; lsu_addr[i] = la; lsu_readop[i] = 3'h1;
    ifu_resp_ready[i] = 1;
    @(negedge clk);
    chk("bp lsu hs", lsu_req_ready[i], 1);
    next_cyc();
    lsu_req_valid[i] = 0;
    ifu_req_valid[i] = 1; ifu_addr[i] = ia;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("bp wait ifu_rdy c%0d", c), ifu_req_ready[i], 0);
      chk($sformatf("bp wait resp c%0d", c), lsu_resp_valid[i], 0);
      next_cyc();
    end
    for (int c = 5; c <= 9; c++) begin
      if (c == 9) lsu_resp_ready[i] = 1;
      @(negedge clk);
      chk($sformatf("bp hold valid c%0d", c), lsu_resp_valid[i], 1);
      chk($sformatf("bp hold rdata c%0d", c), lsu_rdata[i], exp_d);
      chk($sformatf("bp ifu_rdy c%0d", c), ifu_req_ready[i], 0);
      chk($sformatf("bp no access c%0d", c), mem_access[i], 0);
      next_cyc();
    end
    lsu_resp_ready[i] = 0;
    @(negedge clk);
    chk("bp ifu accepted", ifu_req_ready[i], 1);
    chk("bp lsu resp gone", lsu_resp_valid[i], 0);
    next_cyc();
    ifu_req_valid[i] = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp ifu resp c%0d", c), ifu_resp_valid[i], (c == 5));
      if (c == 5) chk("bp ifu rdata", ifu_rdata[i], mem_fn(ia, 3'h2));
      next_cyc();
    end
    chk("bp no writes", wr_cnt[i] - w0, 0);
    clear_inputs();
  endtask

  task automatic seq_reset_wait();
    int i = 1;
    vec_t v;
    do_reset(i);
    lsu_req_valid[i] = 1; lsu_wen[i] = 0; lsu_addr[i] = 32'h8000_5000; lsu_readop[i] = 3'h2;
    lsu_resp_ready[i] = 1;
    @(negedge clk);
    chk("rw hs", lsu_req_ready[i], 1);
    next_cyc();
    lsu_req_valid[i] = 0;
    next_cyc();
    rst = 1;
    next_cyc();
    rst = 0;
    @(negedge clk);
    chk_zero(i, "rw after reset");
    next_cyc();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rw no resp c%0d", c), {30'h0, lsu_resp_valid[i], mem_access[i]}, 0);
      next_cyc();
    end
    v = '{inst: 1, lsu: 0, wen: 0, addr: 32'h8000_0040, wdata: 0, wmask: 0, readop: 0,
          frc: 0, memval: 0, exp_rdata: mem_fn(32'h8000_0040, 3'h2)};
    run_txn(v);
  endtask

  task automatic rand_run(input int i, input int ncyc);
    int lat = i * 3;
    int ops [5] = '{0, 1, 2, 4, 5};
    bit busy = 0, own_lsu = 0, last_lsu = 1, ip = 0, lp = 0, e_wen = 0, rv;
    bit exp_ifu_rdy, exp_lsu_rdy;
    int cnt = 0, stores_exp = 0, w0;
    logic [31:0] e_addr = 0, e_wdata = 0, exp_d = 0;
    logic [7:0] e_wmask = 0;
    logic [2:0] e_op = 0;
    do_reset(i);
    w0 = wr_cnt[i];
    for (int k = 0; k < ncyc; k++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ifu_addr[i] = $urandom & 32'hFFFF_FFFC;
      end
      if (!lp && $urandom_range(0, 2) == 0) begin
        lp = 1; lsu_wen[i] = 1'($urandom_range(0, 1)); lsu_addr[i] = $urandom;
        lsu_wdata[i] = $urandom; lsu_wmask[i] = 8'($urandom);
        lsu_readop[i] = 3'(ops[$urandom_range(0, 4)]);
      end
      ifu_req_valid[i] = ip;
      lsu_req_valid[i] = lp;
      ifu_resp_ready[i] = ($urandom_range(0, 3) != 0);
      lsu_resp_ready[i] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!busy) begin
        exp_ifu_rdy = ip && (!lp || last_lsu);
        exp_lsu_rdy = lp && (!ip || !last_lsu);
        chk("rnd ifu_rdy", ifu_req_ready[i], exp_ifu_rdy);
        chk("rnd lsu_rdy", lsu_req_ready[i], exp_lsu_rdy);
        chk("rnd idle resp", {30'h0, ifu_resp_valid[i], lsu_resp_valid[i]}, 0);
        chk("rnd idle access", mem_access[i], 0);
        if (exp_ifu_rdy) begin
          busy = 1; own_lsu = 0; last_lsu = 0; cnt = 0; ip = 0;
          e_addr = ifu_addr[i]; e_wen = 0; e_op = 3'h2; exp_d = mem_fn(e_addr, 3'h2);
        end else if (exp_lsu_rdy) begin
          busy = 1; own_lsu = 1; last_lsu = 1; cnt = 0; lp = 0;
          e_addr = lsu_addr[i]; e_wen = lsu_wen[i]; e_op = lsu_readop[i];
          e_wdata = lsu_wdata[i]; e_wmask = lsu_wmask[i];
          exp_d = e_wen ? 32'h0 : mem_fn(e_addr, e_op);
          if (e_wen) stores_exp++;
        end
      end else begin
        cnt++;
        rv = (cnt >= lat + 2);
        chk("rnd busy rdy", {30'h0, ifu_req_ready[i], lsu_req_ready[i]}, 0);
        chk("rnd ifu_resp_valid", ifu_resp_valid[i], rv && !own_lsu);
        chk("rnd lsu_resp_valid", lsu_resp_valid[i], rv && own_lsu);
        chk("rnd access", mem_access[i], (cnt == 1));
        if (cnt == 1) begin
          chk("rnd mem_read", mem_read[i], !e_wen);
          chk("rnd mem_wen", mem_wen[i], e_wen);
          chk("rnd mem_raddr", mem_raddr[i], e_addr);
          chk("rnd mem_waddr", mem_waddr[i], e_addr);
          chk("rnd mem_readop", mem_readop[i], e_op);
          if (e_wen) chk("rnd mem_wdata", mem_wdata[i], e_wdata);
          if (e_wen) chk("rnd mem_wmask", mem_wmask[i], e_wmask);
        end
        if (rv) begin
          chk("rnd rdata", own_lsu ? lsu_rdata[i] : ifu_rdata[i], exp_d);
          chk("rnd other rdata", own_lsu ? ifu_rdata[i] : lsu_rdata[i], 0);
          if (own_lsu ? lsu_resp_ready[i] : ifu_resp_ready[i]) busy = 0;
        end
      end
      next_cyc();
    end
    ifu_req_valid[i] = 0; lsu_req_valid[i] = 0;
    ifu_resp_ready[i] = 1; lsu_resp_ready[i] = 1;
    repeat (lat + 4) next_cyc();
    chk("rnd store count", wr_cnt[i] - w0, stores_exp);
    clear_inputs();
  endtask

  initial begin
    vec_t vecs [6];
    vecs[0] = '{inst: 0, lsu: 0, wen: 0, addr: 32'h8000_0000, wdata: 0, wmask: 0, readop: 0,
                frc: 1, memval: 32'h0010_0093, exp_rdata: 32'h0010_0093};
    vecs[1] = '{inst: 0, lsu: 1, wen: 1, addr: 32'h8000_1000, wdata: 32'hDEAD_BEEF,
                wmask: 8'h0F, readop: 3'h2, frc: 0, memval: 0, exp_rdata: 32'h0};
    vecs[2] = '{inst: 1, lsu: 1, wen: 0, addr: 32'h8000_2003, wdata: 0, wmask: 0, readop: 3'h0,
                frc: 1, memval: 32'hFFFF_FF80, exp_rdata: 32'hFFFF_FF80};
    vecs[3] = '{inst: 1, lsu: 0, wen: 0, addr: 32'h8000_0004, wdata: 0, wmask: 0, readop: 0,
                frc: 0, memval: 0, exp_rdata: mem_fn(32'h8000_0004, 3'h2)};
    vecs[4] = '{inst: 0, lsu: 1, wen: 0, addr: 32'h8000_0012, wdata: 0, wmask: 0, readop: 3'h5,
                frc: 0, memval: 0, exp_rdata: mem_fn(32'h8000_0012, 3'h5)};
    vecs[5] = '{inst: 1, lsu: 1, wen: 1, addr: 32'h8000_3000, wdata: 32'h1234_5678,
                wmask: 8'hF0, readop: 3'h2, frc: 0, memval: 0, exp_rdata: 32'h0};
    rst = 1;
    clear_inputs();
    repeat (2) next_cyc();
    do_reset(0);
    do_reset(1);
    for (int n = 0; n < 6; n++) run_txn(vecs[n]);
    seq_alternate();
    seq_backpressure();
    seq_reset_wait();
    rand_run(0, 500);
    rand_run(1, 500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
